// File: rtl/mem_pkg.sv
// Shared MEM-stage encodings: load/store type codes, access sizes and FSM states.
// Imported by the EX/MEM producers as well as the memory access unit.
package mem_pkg;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  localparam logic [1:0] ST_W = 2'b00;
  localparam logic [1:0] ST_H = 2'b01;
  localparam logic [1:0] ST_B = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    RMW_WRITE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } acc_size_e;

  // Unlisted load codes behave as LW.
  function automatic acc_size_e load_size(input logic [2:0] flag);
    case (flag)
      LD_H, LD_HU: load_size = SZ_HALF;
      LD_B, LD_BU: load_size = SZ_BYTE;
      default:     load_size = SZ_WORD;
    endcase
  endfunction

  // Store code 2'b11 behaves as SW.
  function automatic acc_size_e store_size(input logic [1:0] flag);
    case (flag)
      ST_H:    store_size = SZ_HALF;
      ST_B:    store_size = SZ_BYTE;
      default: store_size = SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Combinational big-endian lane logic: extract/extend for loads, merge for
// sub-word stores. Shared by the load-return and read-modify-write paths.
module mem_lane_unit
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_flag,
  input  logic [1:0]  store_flag,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    half_sel = offset[1] ? rdata[15:0] : rdata[31:16];
    case (offset)
      2'd0:    byte_sel = rdata[31:24];
      2'd1:    byte_sel = rdata[23:16];
      2'd2:    byte_sel = rdata[15:8];
      default: byte_sel = rdata[7:0];
    endcase

    case (load_flag)
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'h0000, half_sel};
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'h000000, byte_sel};
      default: load_data = rdata;
    endcase

    merge_data = rdata;
    case (store_flag)
      ST_H: begin
        if (offset[1]) merge_data[15:0]  = store_data[15:0];
        else           merge_data[31:16] = store_data[15:0];
      end
      ST_B: begin
        case (offset)
          2'd0:    merge_data[31:24] = store_data[7:0];
          2'd1:    merge_data[23:16] = store_data[7:0];
          2'd2:    merge_data[15:8]  = store_data[7:0];
          default: merge_data[7:0]   = store_data[7:0];
        endcase
      end
      default: merge_data = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit for a 1-cycle-latency word RAM without byte enables.
// Optional MEM_ALIGN_CHECK_EN suppresses misaligned accesses and flags outAddrError.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       inAddr,
  input  logic [31:0]       inDataRt,
  input  logic              inMemRead,
  input  logic              inMemWrite,
  input  logic [2:0]        inLoadFlag,
  input  logic [1:0]        inStoreFlag,
  output logic [MEM_AW-1:0] memAddr,
  output logic              memRe,
  output logic              memWe,
  output logic [31:0]       memWdata,
  input  logic [31:0]       memRdata,
  output logic [31:0]       outReadData,
  output logic              outStall,
  output logic              outAddrError
);

  mem_state_e        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [1:0]        offset_q, offset_d;
  logic [2:0]        load_flag_q, load_flag_d;
  logic [1:0]        store_flag_q, store_flag_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       read_data_q, read_data_d;
  logic [31:0]       lane_load, lane_merge;
  logic              misaligned;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^inAddr[31:MEM_AW+2];

  mem_lane_unit u_lane (
    .rdata      (memRdata),
    .offset     (offset_q),
    .load_flag  (load_flag_q),
    .store_flag (store_flag_q),
    .store_data (wdata_q),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

`ifdef MEM_ALIGN_CHECK_EN
  acc_size_e req_size;

  always_comb begin
    req_size   = inMemRead ? load_size(inLoadFlag) : store_size(inStoreFlag);
    misaligned = (inMemRead || inMemWrite) &&
                 (((req_size == SZ_WORD) && (inAddr[1:0] != 2'b00)) ||
                  ((req_size == SZ_HALF) && inAddr[0]));
  end
`else
  assign misaligned = 1'b0;
`endif

  assign outAddrError = reset && (state_q == IDLE) && misaligned;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    offset_d     = offset_q;
    load_flag_d  = load_flag_q;
    store_flag_d = store_flag_q;
    wdata_d      = wdata_q;
    read_data_d  = read_data_q;
    memAddr      = addr_q;
    memRe        = 1'b0;
    memWe        = 1'b0;
    memWdata     = wdata_q;
    outStall     = 1'b0;
    outReadData  = read_data_q;

    case (state_q)
      IDLE: begin
        // A simultaneous read and write is treated as a load only.
        if (!misaligned && inMemRead) begin
          memAddr     = inAddr[MEM_AW+1:2];
          addr_d      = inAddr[MEM_AW+1:2];
          memRe       = 1'b1;
          outStall    = 1'b1;
          offset_d    = inAddr[1:0];
          load_flag_d = inLoadFlag;
          state_d     = LOAD_WAIT;
        end else if (!misaligned && inMemWrite) begin
          memAddr = inAddr[MEM_AW+1:2];
          addr_d  = inAddr[MEM_AW+1:2];
          if (store_size(inStoreFlag) == SZ_WORD) begin
            memWe    = 1'b1;
            memWdata = inDataRt;
          end else begin
            memRe        = 1'b1;
            outStall     = 1'b1;
            offset_d     = inAddr[1:0];
            wdata_d      = inDataRt;
            store_flag_d = inStoreFlag;
            state_d      = RMW_WRITE;
          end
        end
      end
      LOAD_WAIT: begin
        outReadData = lane_load;
        read_data_d = lane_load;
        state_d     = IDLE;
      end
      RMW_WRITE: begin
        memWe    = 1'b1;
        memWdata = lane_merge;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset must never let an abandoned access touch the RAM.
    if (!reset) begin
      memRe    = 1'b0;
      memWe    = 1'b0;
      outStall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      offset_q     <= '0;
      load_flag_q  <= '0;
      store_flag_q <= '0;
      wdata_q      <= '0;
      read_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      offset_q     <= offset_d;
      load_flag_q  <= load_flag_d;
      store_flag_q <= store_flag_d;
      wdata_q      <= wdata_d;
      read_data_q  <= read_data_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus a randomized
// pipeline-style stream checked against a byte-arithmetic memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inAddr, inDataRt;
  logic        inMemRead, inMemWrite;
  logic [2:0]  inLoadFlag;
  logic [1:0]  inStoreFlag;
  logic [9:0]  memAddr;
  logic        memRe, memWe;
  logic [31:0] memWdata, memRdata, outReadData;
  logic        outStall, outAddrError;

  logic        poke_en = 1'b0;
  logic [9:0]  poke_addr = '0;
  logic [31:0] poke_data = '0;
  logic [31:0] ram [0:1023];
  logic [31:0] ref_mem [0:15];
  logic [31:0] last_load = '0;
  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_AW(10)) dut (
    .clk(clk), .reset(reset), .inAddr(inAddr), .inDataRt(inDataRt),
    .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inLoadFlag(inLoadFlag),
    .inStoreFlag(inStoreFlag), .memAddr(memAddr), .memRe(memRe), .memWe(memWe),
    .memWdata(memWdata), .memRdata(memRdata), .outReadData(outReadData),
    .outStall(outStall), .outAddrError(outAddrError)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (memWe) ram[memAddr] <= memWdata;
    if (memRe) memRdata <= ram[memAddr];
  end

  function automatic int ld_bytes(input logic [2:0] lf);
    if (lf == 3'd1 || lf == 3'd2) return 2;
    if (lf == 3'd3 || lf == 3'd4) return 1;
    return 4;
  endfunction

  function automatic int st_bytes(input logic [1:0] sf);
    if (sf == 2'd1) return 2;
    if (sf == 2'd2) return 1;
    return 4;
  endfunction

  // Big-endian lane position: shift from the least significant end of the word.
  function automatic int lane_shift(input int bytes, input logic [1:0] off);
    if (bytes == 2) return off[1] ? 0 : 16;
    return 8 * (3 - int'(off));
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] off,
                                           input logic [2:0] lf);
    int n;
    logic [31:0] v;
    n = ld_bytes(lf);
    if (n == 4) return word;
    v = (word >> lane_shift(n, off)) & ((32'h1 << (8 * n)) - 1);
    if ((lf == 3'd1 || lf == 3'd3) && v >= (32'h1 << (8 * n - 1))) v = v - (32'h1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] word, input logic [31:0] data,
                                            input logic [1:0] off, input logic [1:0] sf);
    int n;
    logic [31:0] mask;
    n = st_bytes(sf);
    if (n == 4) return data;
    mask = ((32'h1 << (8 * n)) - 1) << lane_shift(n, off);
    return (word & ~mask) | ((data << lane_shift(n, off)) & mask);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] lf, input logic [1:0] sf);
    inMemRead = rd; inMemWrite = wr; inAddr = a; inDataRt = d;
    inLoadFlag = lf; inStoreFlag = sf;
  endtask

  task automatic poke(input int w, input logic [31:0] d);
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    poke_en = 1'b1; poke_addr = w[9:0]; poke_data = d; ref_mem[w] = d;
    next_cycle();
    poke_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0000_0044, 32'h1234_5678, LD_W, ST_B);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (memRe !== 1'b0) begin errors++; $display("[TB] FAIL rst_memRe: got %0b expected 0", memRe); end
      checks++; if (memWe !== 1'b0) begin errors++; $display("[TB] FAIL rst_memWe: got %0b expected 0", memWe); end
      checks++; if (outStall !== 1'b0) begin errors++; $display("[TB] FAIL rst_stall: got %0b expected 0", outStall); end
      checks++; if (outAddrError !== 1'b0) begin errors++; $display("[TB] FAIL rst_adderr: got %0b expected 0", outAddrError); end
      next_cycle();
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outReadData !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h expected 0", outReadData); end
    checks++; if (memAddr !== 10'd0) begin errors++; $display("[TB] FAIL rst_addr: got %h expected 0", memAddr); end
    checks++; if (outStall !== 1'b0) begin errors++; $display("[TB] FAIL rst_idle_stall: got %0b expected 0", outStall); end
  endtask

  task automatic test_store_word();
    next_cycle();
    drive(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, LD_W, ST_W);
    @(negedge clk);
    checks++; if (memWe !== 1'b1) begin errors++; $display("[TB] FAIL sw_we: got %0b expected 1", memWe); end
    checks++; if (memAddr !== 10'd4) begin errors++; $display("[TB] FAIL sw_addr: got %h expected 4", memAddr); end
    checks++; if (memWdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", memWdata); end
    checks++; if (outStall !== 1'b0 || memRe !== 1'b0) begin errors++; $display("[TB] FAIL sw_nostall: got stall %0b re %0b expected 0 0", outStall, memRe); end
    ref_mem[4] = 32'hDEAD_BEEF;
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (memAddr !== 10'd4) begin errors++; $display("[TB] FAIL sw_addr_hold: got %h expected 4", memAddr); end
    checks++; if (ram[4] !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sw_ram: got %h expected deadbeef", ram[4]); end
    checks++; if (outStall !== 1'b0) begin errors++; $display("[TB] FAIL sw_idle_stall: got %0b expected 0", outStall); end
  endtask

  task automatic test_subword_load();
    logic [31:0] words [4] = '{32'h1122_3380, 32'h1122_3380, 32'hAAAA_8001, 32'hAAAA_8001};
    logic [31:0] addrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [2:0]  flags [4] = '{LD_B, LD_BU, LD_H, LD_HU};
    logic [31:0] exps  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_AAAA};
    for (int k = 0; k < 4; k++) begin
      poke(4, words[k]);
      next_cycle();
      drive(1'b1, 1'b0, addrs[k], 32'h0, flags[k], ST_W);
      @(negedge clk);
      checks++; if (outStall !== 1'b1 || memRe !== 1'b1) begin errors++; $display("[TB] FAIL ld%0d_issue: got stall %0b re %0b expected 1 1", k, outStall, memRe); end
      checks++; if (memAddr !== 10'd4) begin errors++; $display("[TB] FAIL ld%0d_addr: got %h expected 4", k, memAddr); end
      next_cycle();
      @(negedge clk);
      checks++; if (outStall !== 1'b0 || memRe !== 1'b0) begin errors++; $display("[TB] FAIL ld%0d_wait: got stall %0b re %0b expected 0 0", k, outStall, memRe); end
      checks++; if (outReadData !== exps[k]) begin errors++; $display("[TB] FAIL ld%0d_data: got %h expected %h", k, outReadData, exps[k]); end
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
      @(negedge clk);
      checks++; if (outReadData !== exps[k]) begin errors++; $display("[TB] FAIL ld%0d_hold: got %h expected %h", k, outReadData, exps[k]); end
      last_load = exps[k];
    end
  endtask

  task automatic test_rmw_store();
    logic [31:0] addrs [2] = '{32'h21, 32'h22};
    logic [31:0] datas [2] = '{32'h0000_00CC, 32'h0000_5566};
    logic [1:0]  flags [2] = '{ST_B, ST_H};
    logic [31:0] exps  [2] = '{32'h11CC_3344, 32'h1122_5566};
    for (int k = 0; k < 2; k++) begin
      poke(8, 32'h1122_3344);
      next_cycle();
      drive(1'b0, 1'b1, addrs[k], datas[k], LD_W, flags[k]);
      @(negedge clk);
      checks++; if (memRe !== 1'b1 || outStall !== 1'b1 || memWe !== 1'b0) begin errors++; $display("[TB] FAIL rmw%0d_read: got re %0b stall %0b we %0b expected 1 1 0", k, memRe, outStall, memWe); end
      checks++; if (memAddr !== 10'd8) begin errors++; $display("[TB] FAIL rmw%0d_addr: got %h expected 8", k, memAddr); end
      next_cycle();
      @(negedge clk);
      checks++; if (memWe !== 1'b1 || outStall !== 1'b0) begin errors++; $display("[TB] FAIL rmw%0d_write: got we %0b stall %0b expected 1 0", k, memWe, outStall); end
      checks++; if (memWdata !== exps[k]) begin errors++; $display("[TB] FAIL rmw%0d_wdata: got %h expected %h", k, memWdata, exps[k]); end
      next_cycle();
      drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
      @(negedge clk);
      checks++; if (ram[8] !== exps[k]) begin errors++; $display("[TB] FAIL rmw%0d_ram: got %h expected %h", k, ram[8], exps[k]); end
      ref_mem[8] = exps[k];
    end
  endtask

  task automatic test_reset_in_rmw();
    poke(8, 32'h1122_3344);
    next_cycle();
    drive(1'b1, 1'b0, 32'h20, 32'h0, LD_W, ST_W);
    next_cycle();
    @(negedge clk);
    checks++; if (outReadData !== 32'h1122_3344) begin errors++; $display("[TB] FAIL rrmw_preload: got %h expected 11223344", outReadData); end
    next_cycle();
    drive(1'b0, 1'b1, 32'h21, 32'h0000_00CC, LD_W, ST_B);
    @(negedge clk);
    checks++; if (outStall !== 1'b1) begin errors++; $display("[TB] FAIL rrmw_issue: got %0b expected 1", outStall); end
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (memWe !== 1'b0 || memRe !== 1'b0 || outStall !== 1'b0) begin errors++; $display("[TB] FAIL rrmw_gate%0d: got we %0b re %0b stall %0b expected 0 0 0", c, memWe, memRe, outStall); end
      next_cycle();
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outReadData !== 32'h0) begin errors++; $display("[TB] FAIL rrmw_rdata: got %h expected 0", outReadData); end
    checks++; if (outStall !== 1'b0 || memWe !== 1'b0) begin errors++; $display("[TB] FAIL rrmw_idle: got stall %0b we %0b expected 0 0", outStall, memWe); end
    checks++; if (ram[8] !== 32'h1122_3344) begin errors++; $display("[TB] FAIL rrmw_ram: got %h expected 11223344", ram[8]); end
    last_load = 32'h0;
    next_cycle();
    drive(1'b1, 1'b0, 32'h20, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outStall !== 1'b1) begin errors++; $display("[TB] FAIL rrmw_accept: got %0b expected 1", outStall); end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    last_load = 32'h1122_3344;
  endtask

  task automatic test_priority();
    poke(9, 32'h0102_0304);
    next_cycle();
    drive(1'b1, 1'b1, 32'h24, 32'hFFFF_FFFF, LD_W, ST_W);
    @(negedge clk);
    checks++; if (memWe !== 1'b0 || memRe !== 1'b1) begin errors++; $display("[TB] FAIL prio_issue: got we %0b re %0b expected 0 1", memWe, memRe); end
    next_cycle();
    @(negedge clk);
    checks++; if (memWe !== 1'b0 || outReadData !== 32'h0102_0304) begin errors++; $display("[TB] FAIL prio_load: got we %0b data %h expected 0 01020304", memWe, outReadData); end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (ram[9] !== 32'h0102_0304) begin errors++; $display("[TB] FAIL prio_ram: got %h expected 01020304", ram[9]); end
    last_load = 32'h0102_0304;
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    next_cycle();
    drive(1'b1, 1'b0, 32'h06, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outAddrError !== 1'b1) begin errors++; $display("[TB] FAIL al_lw_err: got %0b expected 1", outAddrError); end
    checks++; if (memRe !== 1'b0 || outStall !== 1'b0) begin errors++; $display("[TB] FAIL al_lw_supp: got re %0b stall %0b expected 0 0", memRe, outStall); end
    next_cycle();
    drive(1'b0, 1'b1, 32'h05, 32'h1234, LD_W, ST_H);
    @(negedge clk);
    checks++; if (outAddrError !== 1'b1 || memRe !== 1'b0 || memWe !== 1'b0) begin errors++; $display("[TB] FAIL al_sh: got err %0b re %0b we %0b expected 1 0 0", outAddrError, memRe, memWe); end
    checks++; if (outReadData !== last_load) begin errors++; $display("[TB] FAIL al_rdata: got %h expected %h", outReadData, last_load); end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outAddrError !== 1'b0) begin errors++; $display("[TB] FAIL al_pulse: got %0b expected 0", outAddrError); end
`else
    poke(1, 32'h0BAD_F00D);
    next_cycle();
    drive(1'b1, 1'b0, 32'h06, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (outAddrError !== 1'b0 || outStall !== 1'b1) begin errors++; $display("[TB] FAIL al_lw_issue: got err %0b stall %0b expected 0 1", outAddrError, outStall); end
    next_cycle();
    @(negedge clk);
    checks++; if (outReadData !== 32'h0BAD_F00D) begin errors++; $display("[TB] FAIL al_lw_data: got %h expected 0badf00d", outReadData); end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    last_load = 32'h0BAD_F00D;
`endif
  endtask

  // EX/MEM only advances when the previous cycle did not stall.
  task automatic test_back_to_back();
    int idx = 0, cyc = 0, stalls = 0, res = 0, wes = 0;
    logic [31:0] got_load = '0, got_wdata = '0;
    poke(2, 32'hCAFE_F00D);
    poke(9, 32'h5566_7788);
    while (idx < 2 && cyc < 12) begin
      next_cycle();
      if (idx == 0) drive(1'b1, 1'b0, 32'h08, 32'h0, LD_W, ST_W);
      else          drive(1'b0, 1'b1, 32'h27, 32'h0000_0099, LD_W, ST_B);
      @(negedge clk);
      if (memRe) res++;
      if (memWe) begin wes++; got_wdata = memWdata; end
      if (outStall) stalls++;
      else begin
        if (idx == 0) got_load = outReadData;
        idx++;
      end
      cyc++;
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    checks++; if (idx != 2) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d requests retired expected 2", idx); end
    checks++; if (stalls != 2) begin errors++; $display("[TB] FAIL b2b_stalls: got %0d expected 2", stalls); end
    checks++; if (res != 2 || wes != 1) begin errors++; $display("[TB] FAIL b2b_ports: got re %0d we %0d expected 2 1", res, wes); end
    checks++; if (got_load !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL b2b_load: got %h expected cafef00d", got_load); end
    checks++; if (got_wdata !== 32'h5566_7799) begin errors++; $display("[TB] FAIL b2b_wdata: got %h expected 55667799", got_wdata); end
    checks++; if (ram[9] !== 32'h5566_7799) begin errors++; $display("[TB] FAIL b2b_ram: got %h expected 55667799", ram[9]); end
    ref_mem[9] = 32'h5566_7799;
    last_load = 32'hCAFE_F00D;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      int kind, w, bytes;
      logic rd, wr, mis, exp_stall, exp_sw;
      logic [31:0] a, d, exp;
      logic [2:0] lf;
      logic [1:0] sf;
      kind = $urandom_range(0, 4);
      rd = (kind == 0 || kind == 3);
      wr = (kind == 1 || kind == 2 || kind == 3);
      a = $urandom; a[11:6] = 6'b0;
      d = $urandom;
      lf = 3'($urandom_range(0, 7));
      sf = 2'($urandom_range(0, 3));
      w = int'(a[5:2]);
      bytes = rd ? ld_bytes(lf) : st_bytes(sf);
      mis = ALIGN && (rd || wr) && ((bytes == 4 && a[1:0] != 2'b00) || (bytes == 2 && a[0]));
      exp_stall = !mis && (rd || (wr && bytes != 4));
      exp_sw = !mis && !rd && wr && bytes == 4;
      next_cycle();
      drive(rd, wr, a, d, lf, sf);
      @(negedge clk);
      checks++; if (outAddrError !== mis) begin errors++; $display("[TB] FAIL rnd%0d_err: got %0b expected %0b", n, outAddrError, mis); end
      checks++; if (outStall !== exp_stall || memRe !== exp_stall) begin errors++; $display("[TB] FAIL rnd%0d_stall: got stall %0b re %0b expected %0b", n, outStall, memRe, exp_stall); end
      checks++; if (memWe !== exp_sw) begin errors++; $display("[TB] FAIL rnd%0d_we: got %0b expected %0b", n, memWe, exp_sw); end
      if (exp_sw || exp_stall) begin
        checks++; if (memAddr !== 10'(w)) begin errors++; $display("[TB] FAIL rnd%0d_addr: got %h expected %h", n, memAddr, w); end
      end
      if (exp_sw) begin
        checks++; if (memWdata !== d) begin errors++; $display("[TB] FAIL rnd%0d_sw: got %h expected %h", n, memWdata, d); end
        ref_mem[w] = d;
      end
      if (!exp_stall) begin
        checks++; if (outReadData !== last_load) begin errors++; $display("[TB] FAIL rnd%0d_hold: got %h expected %h", n, outReadData, last_load); end
      end else begin
        next_cycle();
        @(negedge clk);
        checks++; if (outStall !== 1'b0 || memRe !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_second: got stall %0b re %0b expected 0 0", n, outStall, memRe); end
        if (rd) begin
          exp = ref_load(ref_mem[w], a[1:0], lf);
          checks++; if (outReadData !== exp || memWe !== 1'b0) begin errors++; $display("[TB] FAIL rnd%0d_load: got %h we %0b expected %h 0", n, outReadData, memWe, exp); end
          last_load = exp;
        end else begin
          exp = ref_merge(ref_mem[w], d, a[1:0], sf);
          checks++; if (memWe !== 1'b1 || memWdata !== exp) begin errors++; $display("[TB] FAIL rnd%0d_rmw: got we %0b %h expected 1 %h", n, memWe, memWdata, exp); end
          ref_mem[w] = exp;
        end
      end
    end
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, LD_W, ST_W);
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      checks++; if (ram[i] !== ref_mem[i]) begin errors++; $display("[TB] FAIL rnd_ram%0d: got %h expected %h", i, ram[i], ref_mem[i]); end
    end
  endtask

  initial begin
    test_reset();
    for (int i = 0; i < 16; i++) poke(i, $urandom);
    test_store_word();
    test_subword_load();
    test_rmw_store();
    test_reset_in_rmw();
    test_priority();
    test_align();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
